// File: rtl/ast_symbol_downsizer.sv
// Avalon-ST width down-converter: splits each sink beat into RATIO source beats,
// preserving packet framing, empty, symbol order and backpressure on both sides.
module ast_symbol_downsizer #(
  parameter int BYTE_W             = 8,
  parameter int AST_SINK_SYMBOLS   = 8,
  parameter int AST_SOURCE_SYMBOLS = 1,
  parameter int AST_SINK_ORDER     = 1,
  parameter int AST_SOURCE_ORDER   = 1,
  parameter int PKT_CNT_W          = 32,
  localparam int RATIO          = AST_SINK_SYMBOLS / AST_SOURCE_SYMBOLS,
  localparam int SINK_EMPTY_W   = (AST_SINK_SYMBOLS == 1) ? 1 : $clog2(AST_SINK_SYMBOLS),
  localparam int SOURCE_EMPTY_W = (AST_SOURCE_SYMBOLS == 1) ? 1 : $clog2(AST_SOURCE_SYMBOLS),
  localparam int SINK_W         = AST_SINK_SYMBOLS * BYTE_W,
  localparam int SOURCE_W       = AST_SOURCE_SYMBOLS * BYTE_W
) (
  input  logic                      main_clk_i,
  input  logic                      main_arst_n_i,
  input  logic [SINK_W-1:0]         ast_sink_data_i,
  output logic                      ast_sink_ready_o,
  input  logic                      ast_sink_valid_i,
  input  logic [SINK_EMPTY_W-1:0]   ast_sink_empty_i,
  input  logic                      ast_sink_startofpacket_i,
  input  logic                      ast_sink_endofpacket_i,
  output logic [SOURCE_W-1:0]       ast_source_data_o,
  input  logic                      ast_source_ready_i,
  output logic                      ast_source_valid_o,
  output logic [SOURCE_EMPTY_W-1:0] ast_source_empty_o,
  output logic                      ast_source_startofpacket_o,
  output logic                      ast_source_endofpacket_o,
  output logic [PKT_CNT_W-1:0]      pkt_cnt_o,
  output logic                      proto_err_o
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int V_W   = $clog2(AST_SINK_SYMBOLS + 1);

  if ((AST_SOURCE_SYMBOLS < 1) || (AST_SINK_SYMBOLS % AST_SOURCE_SYMBOLS != 0)) begin : g_ratio_check
    $error("AST_SINK_SYMBOLS must be an integer multiple of AST_SOURCE_SYMBOLS");
  end

  logic                 live_q;
  logic                 held_q;
  logic [SINK_W-1:0]    hold_q;
  logic [V_W-1:0]       hold_v_q;
  logic [IDX_W-1:0]     last_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 sop_q;
  logic                 eop_q;
  logic                 in_pkt_q;
  logic                 err_q;
  logic [PKT_CNT_W-1:0] pkt_cnt_q;

  logic                 last_chunk;
  logic                 sink_ready;
  logic                 sink_fire;
  logic                 src_fire;

  assign last_chunk = (idx_q == last_q);
  // live_q keeps sink ready low while reset is asserted and for the release edge
  assign sink_ready = live_q && (!held_q || (last_chunk && ast_source_ready_i));
  assign sink_fire  = ast_sink_valid_i && sink_ready;
  assign src_fire   = held_q && ast_source_ready_i;

  // Capture path: reorder the sink beat into time order and zero unused symbols
  logic [SINK_W-1:0] cap_sym;
  logic [V_W-1:0]    cap_v;
  logic [IDX_W-1:0]  cap_last;
  logic              cap_empty_bad;
  int                cap_v_int;
  int                cap_c_int;

  always_comb begin
    cap_empty_bad = ast_sink_endofpacket_i && (int'(ast_sink_empty_i) >= AST_SINK_SYMBOLS);
    cap_v_int     = AST_SINK_SYMBOLS;
    if (ast_sink_endofpacket_i && !cap_empty_bad)
      cap_v_int = AST_SINK_SYMBOLS - int'(ast_sink_empty_i);
    cap_c_int = (cap_v_int + AST_SOURCE_SYMBOLS - 1) / AST_SOURCE_SYMBOLS;
    cap_v     = V_W'(cap_v_int);
    cap_last  = IDX_W'(cap_c_int - 1);
    cap_sym   = '0;
    for (int t = 0; t < AST_SINK_SYMBOLS; t++) begin
      if (t < cap_v_int) begin
        if (AST_SINK_ORDER != 0)
          cap_sym[t*BYTE_W +: BYTE_W] = ast_sink_data_i[(AST_SINK_SYMBOLS-1-t)*BYTE_W +: BYTE_W];
        else
          cap_sym[t*BYTE_W +: BYTE_W] = ast_sink_data_i[t*BYTE_W +: BYTE_W];
      end
    end
  end

  logic [SOURCE_W-1:0]       src_data;
  logic [SOURCE_EMPTY_W-1:0] src_empty;
  int                        src_t;

  always_comb begin
    src_data = '0;
    src_t    = 0;
    for (int j = 0; j < AST_SOURCE_SYMBOLS; j++) begin
      src_t = int'(idx_q) * AST_SOURCE_SYMBOLS + j;
      if (src_t < AST_SINK_SYMBOLS) begin
        if (AST_SOURCE_ORDER != 0)
          src_data[(AST_SOURCE_SYMBOLS-1-j)*BYTE_W +: BYTE_W] = hold_q[src_t*BYTE_W +: BYTE_W];
        else
          src_data[j*BYTE_W +: BYTE_W] = hold_q[src_t*BYTE_W +: BYTE_W];
      end
    end
    src_empty = '0;
    if (eop_q && last_chunk)
      src_empty = SOURCE_EMPTY_W'((int'(last_q) + 1) * AST_SOURCE_SYMBOLS - int'(hold_v_q));
  end

  always_ff @(posedge main_clk_i or negedge main_arst_n_i) begin
    if (!main_arst_n_i) begin
      live_q    <= 1'b0;
      held_q    <= 1'b0;
      hold_q    <= '0;
      hold_v_q  <= '0;
      last_q    <= '0;
      idx_q     <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      in_pkt_q  <= 1'b0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      live_q <= 1'b1;
      if (src_fire) begin
        if (last_chunk) begin
          held_q <= 1'b0;
          idx_q  <= '0;
          if (eop_q)
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
      // A load may coincide with the last chunk leaving; it overrides the clear above
      if (sink_fire) begin
        held_q   <= 1'b1;
        hold_q   <= cap_sym;
        hold_v_q <= cap_v;
        last_q   <= cap_last;
        idx_q    <= '0;
        sop_q    <= ast_sink_startofpacket_i;
        eop_q    <= ast_sink_endofpacket_i;
        if (ast_sink_endofpacket_i)
          in_pkt_q <= 1'b0;
        else if (ast_sink_startofpacket_i)
          in_pkt_q <= 1'b1;
        if ((ast_sink_startofpacket_i && in_pkt_q) ||
            (!ast_sink_startofpacket_i && !in_pkt_q) || cap_empty_bad)
          err_q <= 1'b1;
      end
    end
  end

  assign ast_sink_ready_o           = sink_ready;
  assign ast_source_valid_o         = held_q;
  assign ast_source_data_o          = held_q ? src_data : '0;
  assign ast_source_empty_o         = held_q ? src_empty : '0;
  assign ast_source_startofpacket_o = held_q && sop_q && (idx_q == '0);
  assign ast_source_endofpacket_o   = held_q && eop_q && last_chunk;
  assign pkt_cnt_o                  = pkt_cnt_q;
  assign proto_err_o                = err_q;

endmodule

// File: tb/tb_ast_symbol_downsizer.sv
// Directed bench for ast_symbol_downsizer: 8->1 instance plus an 8->4 instance.
`timescale 1ns/1ps
module tb_ast_symbol_downsizer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] sink_data;
  logic        sink_valid, sink_sop, sink_eop;
  logic [2:0]  sink_empty;
  logic        sink_ready;
  logic        src_ready;
  logic [7:0]  src_data;
  logic        src_valid, src_sop, src_eop;
  logic [0:0]  src_empty;
  logic [31:0] pkt_cnt;
  logic        proto_err;

  logic [63:0] s4_data;
  logic        s4_valid, s4_sop, s4_eop;
  logic [2:0]  s4_empty;
  logic        s4_ready;
  logic        s4_src_ready;
  logic [31:0] s4_src_data;
  logic        s4_src_valid, s4_src_sop, s4_src_eop;
  logic [1:0]  s4_src_empty;
  logic [31:0] s4_pkt_cnt;
  logic        s4_err;

  ast_symbol_downsizer dut (
    .main_clk_i(clk), .main_arst_n_i(rst_n),
    .ast_sink_data_i(sink_data), .ast_sink_ready_o(sink_ready), .ast_sink_valid_i(sink_valid),
    .ast_sink_empty_i(sink_empty), .ast_sink_startofpacket_i(sink_sop), .ast_sink_endofpacket_i(sink_eop),
    .ast_source_data_o(src_data), .ast_source_ready_i(src_ready), .ast_source_valid_o(src_valid),
    .ast_source_empty_o(src_empty), .ast_source_startofpacket_o(src_sop), .ast_source_endofpacket_o(src_eop),
    .pkt_cnt_o(pkt_cnt), .proto_err_o(proto_err)
  );

  ast_symbol_downsizer #(.AST_SOURCE_SYMBOLS(4)) dut4 (
    .main_clk_i(clk), .main_arst_n_i(rst_n),
    .ast_sink_data_i(s4_data), .ast_sink_ready_o(s4_ready), .ast_sink_valid_i(s4_valid),
    .ast_sink_empty_i(s4_empty), .ast_sink_startofpacket_i(s4_sop), .ast_sink_endofpacket_i(s4_eop),
    .ast_source_data_o(s4_src_data), .ast_source_ready_i(s4_src_ready), .ast_source_valid_o(s4_src_valid),
    .ast_source_empty_o(s4_src_empty), .ast_source_startofpacket_o(s4_src_sop), .ast_source_endofpacket_o(s4_src_eop),
    .pkt_cnt_o(s4_pkt_cnt), .proto_err_o(s4_err)
  );

  typedef struct packed { logic [7:0] d; logic s; logic e; logic [0:0] em; } beat_t;
  typedef struct packed { logic [31:0] d; logic s; logic e; logic [1:0] em; } beat4_t;

  int checks = 0;
  int errors = 0;

  beat_t mon_q[$];
  beat_t prev_b;
  logic  prev_stall = 1'b0;
  int    stall_errs = 0;
  logic  rnd_en = 1'b0;

  always @(negedge clk) begin
    beat_t cur;
    cur = {src_data, src_sop, src_eop, src_empty};
    if (rst_n) begin
      if (prev_stall && (!src_valid || cur !== prev_b)) stall_errs++;
      if (src_valid && src_ready) mon_q.push_back(cur);
      prev_stall = src_valid && !src_ready;
      prev_b     = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_en) src_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [63:0] d, input logic s, input logic e,
                           input logic [2:0] emp, output int waits);
    waits = 0;
    sink_data = d; sink_sop = s; sink_eop = e; sink_empty = emp; sink_valid = 1'b1;
    @(negedge clk);
    while (!sink_ready && waits < 2000) begin @(negedge clk); waits++; end
    if (!sink_ready) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout: sink_ready=%0b after %0d cycles, required 1", sink_ready, waits);
    end
    @(posedge clk); #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string name);
    int cyc = 0;
    while (mon_q.size() < n && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    checks++;
    if (mon_q.size() != n) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d, required %0d", name, mon_q.size(), n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sink_valid = 1'b0; s4_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_q.delete();
  endtask

  task automatic check_beat(input string name, input int i, input beat_t exp_b);
    beat_t got;
    got = (i < mon_q.size()) ? mon_q[i] : '1;
    checks++;
    if (got !== exp_b) begin
      errors++;
      $display("FAIL %s_beat%0d: got d=%h sop=%0b eop=%0b empty=%0d, required d=%h sop=%0b eop=%0b empty=%0d",
               name, i, got.d, got.s, got.e, got.em, exp_b.d, exp_b.s, exp_b.e, exp_b.em);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (sink_ready !== 1'b0) begin errors++; $display("FAIL reset_sink_ready: got %0b, required 0", sink_ready); end
    checks++; if (src_valid !== 1'b0) begin errors++; $display("FAIL reset_src_valid: got %0b, required 0", src_valid); end
    checks++; if (src_data !== 8'h00) begin errors++; $display("FAIL reset_src_data: got %h, required 00", src_data); end
    checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d, required 0", pkt_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %0b, required 0", proto_err); end
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    int w;
    src_ready = 1'b1;
    mon_q.delete();
    send_beat(64'h0706050403020100, 1'b1, 1'b1, 3'd0, w);
    checks++;
    if (src_valid !== 1'b1) begin errors++; $display("FAIL single_latency: src_valid=%0b one cycle after accept, required 1", src_valid); end
    wait_beats(8, "single");
    for (int i = 0; i < 8; i++) check_beat("single", i, {8'(7 - i), (i == 0), (i == 7), 1'b0});
    checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL single_pkt_cnt: got %0d, required 1", pkt_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL single_proto_err: got %0b, required 0", proto_err); end
  endtask

  task automatic test_two_beat();
    int w;
    logic [63:0] a, b;
    a = 64'h1112131415161718;
    b = 64'h2122232425262728;
    mon_q.delete();
    send_beat(a, 1'b1, 1'b0, 3'd0, w);
    send_beat(b, 1'b0, 1'b1, 3'd5, w);
    checks++; if (w != 7) begin errors++; $display("FAIL two_beat_ready_low: got %0d cycles, required 7", w); end
    wait_beats(11, "two_beat");
    for (int i = 0; i < 11; i++)
      check_beat("two_beat", i, {(i < 8) ? a[(7 - i)*8 +: 8] : b[(7 - (i - 8))*8 +: 8], (i == 0), (i == 10), 1'b0});
    checks++; if (pkt_cnt !== 32'd2) begin errors++; $display("FAIL two_beat_pkt_cnt: got %0d, required 2", pkt_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL two_beat_proto_err: got %0b, required 0", proto_err); end
  endtask

  task automatic test_source4();
    int n = 0;
    beat4_t q4[$];
    beat4_t got, exp_b;
    s4_data = 64'h0706050403020100; s4_sop = 1'b1; s4_eop = 1'b1; s4_empty = 3'd3; s4_valid = 1'b1;
    @(negedge clk);
    while (!s4_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!s4_ready) begin errors++; $display("FAIL source4_sink_ready: got %0b, required 1", s4_ready); end
    @(posedge clk); #1;
    s4_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s4_src_valid) q4.push_back({s4_src_data, s4_src_sop, s4_src_eop, s4_src_empty});
    end
    checks++;
    if (q4.size() != 2) begin errors++; $display("FAIL source4_beat_count: got %0d, required 2", q4.size()); end
    for (int i = 0; i < 2; i++) begin
      got   = (i < q4.size()) ? q4[i] : '1;
      exp_b = (i == 0) ? {32'h07060504, 1'b1, 1'b0, 2'd0} : {32'h03000000, 1'b0, 1'b1, 2'd3};
      checks++;
      if (got !== exp_b) begin
        errors++;
        $display("FAIL source4_beat%0d: got d=%h sop=%0b eop=%0b empty=%0d, required d=%h sop=%0b eop=%0b empty=%0d",
                 i, got.d, got.s, got.e, got.em, exp_b.d, exp_b.s, exp_b.e, exp_b.em);
      end
    end
    @(posedge clk); #1;
    checks++; if (s4_pkt_cnt !== 32'd1) begin errors++; $display("FAIL source4_pkt_cnt: got %0d, required 1", s4_pkt_cnt); end
  endtask

  task automatic test_proto_err();
    int w;
    logic [63:0] c, d;
    c = 64'hA0A1A2A3A4A5A6A7;
    d = 64'hB0B1B2B3B4B5B6B7;
    do_reset();
    src_ready = 1'b1;
    send_beat(c, 1'b1, 1'b0, 3'd0, w);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_first_sop: got %0b, required 0", proto_err); end
    send_beat(d, 1'b1, 1'b1, 3'd0, w);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_second_sop: got %0b, required 1", proto_err); end
    wait_beats(16, "proto");
    check_beat("proto", 8, {8'hB0, 1'b1, 1'b0, 1'b0});
    check_beat("proto", 15, {8'hB7, 1'b0, 1'b1, 1'b0});
    repeat (10) @(posedge clk);
    #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %0b, required 1", proto_err); end
  endtask

  task automatic test_reset_mid();
    int w;
    int cyc = 0;
    do_reset();
    src_ready = 1'b1;
    send_beat(64'hC0C1C2C3C4C5C6C7, 1'b1, 1'b0, 3'd0, w);
    while (mon_q.size() < 3 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++; if (src_valid !== 1'b1) begin errors++; $display("FAIL rstmid_4th_chunk_valid: got %0b, required 1", src_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (src_valid !== 1'b0) begin errors++; $display("FAIL rstmid_src_valid: got %0b, required 0", src_valid); end
    checks++; if (sink_ready !== 1'b0) begin errors++; $display("FAIL rstmid_sink_ready: got %0b, required 0", sink_ready); end
    checks++; if ({src_data, src_sop, src_eop} !== 10'd0) begin errors++; $display("FAIL rstmid_src_fields: got %h, required 0", {src_data, src_sop, src_eop}); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_q.delete();
    checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_pkt_cnt: got %0d, required 0", pkt_cnt); end
    checks++; if (src_valid !== 1'b0) begin errors++; $display("FAIL rstmid_partial: src_valid=%0b after release, required 0", src_valid); end
    send_beat(64'hD7D6D5D4D3D2D1D0, 1'b1, 1'b1, 3'd0, w);
    wait_beats(8, "rstmid_next");
    for (int i = 0; i < 8; i++) check_beat("rstmid_next", i, {8'hD7 - 8'(i), (i == 0), (i == 7), 1'b0});
    checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL rstmid_next_pkt_cnt: got %0d, required 1", pkt_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rstmid_proto_err: got %0b, required 0", proto_err); end
  endtask

  task automatic test_random();
    int w, len, v;
    logic [63:0] d;
    logic [2:0] emp;
    beat_t exp_q[$];
    do_reset();
    stall_errs = 0;
    rnd_en = 1'b1;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        d   = {$urandom, $urandom};
        emp = 3'($urandom_range(0, 7));
        v   = (b == len - 1) ? 8 - int'(emp) : 8;
        for (int t = 0; t < v; t++)
          exp_q.push_back({d[(7 - t)*8 +: 8], (b == 0 && t == 0), (b == len - 1 && t == v - 1), 1'b0});
        send_beat(d, (b == 0), (b == len - 1), emp, w);
      end
    end
    wait_beats(exp_q.size(), "random");
    rnd_en = 1'b0;
    @(posedge clk); #2;
    src_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) check_beat("random", i, exp_q[i]);
    checks++; if (stall_errs != 0) begin errors++; $display("FAIL random_stall_stability: got %0d changes, required 0", stall_errs); end
    checks++; if (pkt_cnt !== 32'd100) begin errors++; $display("FAIL random_pkt_cnt: got %0d, required 100", pkt_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL random_proto_err: got %0b, required 0", proto_err); end
  endtask

  initial begin
    sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_empty = '0;
    s4_data = '0; s4_valid = 1'b0; s4_sop = 1'b0; s4_eop = 1'b0; s4_empty = '0;
    src_ready = 1'b1; s4_src_ready = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_single_beat();
    test_two_beat();
    test_source4();
    test_proto_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
